if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/wisc_pkg.sv | 19 +
 rtl/ifq_ptr.sv | 46 ++++
 rtl/if_id_queue.sv | 150 +++++++++++++++
 tb/tb_if_id_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wisc_pkg
//  Description : Shared fetch/decode definitions: word width, halt opcode
//                and the {pc, instr} entry carried by the IF/ID queue.
//  Revision    : 1.0  initial release
// ============================================================================
package wisc_pkg;

    localparam int         WORD_W  = 16;
    localparam logic [3:0] OPC_HLT = 4'hF;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifq_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : ifq_ptr
//  Description : Wrapping queue pointer with increment and synchronous clear.
//                Counts 0..DEPTH-1 and returns to 0. Clear beats increment.
//  Revision    : 1.0  initial release
// ============================================================================
module ifq_ptr #(
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,      // synchronous, active-low
    input  wire logic                     i_inc,
    input  wire logic                     i_clr,
    output logic [$clog2(DEPTH)-1:0]      o_ptr
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

    logic [c_PTR_W-1:0] r_ptr_q;
    logic [c_PTR_W-1:0] w_ptr_d;

    // Next pointer: clear to zero, else step with wrap at the last slot
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (i_clr) begin
            w_ptr_d = '0;
        end else if (i_inc) begin
            w_ptr_d = (r_ptr_q == c_LAST) ? '0 : r_ptr_q + 1'b1;
        end
    end

    // Pointer register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign o_ptr = r_ptr_q;

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue
//  Description : DEPTH-entry FIFO of {pc, instr} between fetch and decode.
//                No bypass: a pushed entry appears at the outputs the cycle
//                after the push. Flush empties the queue in one cycle.
//                Optional macro IFQ_HALT_DETECT_EN: a pushed HLT opcode sets
//                a sticky halt that blocks further pushes until flush/reset.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_queue
    import wisc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,          // synchronous, active-low
    input  wire logic                  in_valid,
    output logic                       in_ready,
    input  wire logic [15:0]           in_pc,
    input  wire logic [15:0]           in_instr,
    output logic                       out_valid,
    input  wire logic                  out_ready,
    output logic [15:0]                out_pc,
    output logic [15:0]                out_pc_plus2,
    output logic [15:0]                out_instr,
    input  wire logic                  flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halted
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    fetch_entry_t        r_mem_q [DEPTH];
    fetch_entry_t        w_mem_d [DEPTH];
    logic [c_CNT_W-1:0]  r_count_q;
    logic [c_CNT_W-1:0]  w_count_d;
    logic [c_PTR_W-1:0]  w_wr_ptr;
    logic [c_PTR_W-1:0]  w_rd_ptr;
    logic                w_push;
    logic                w_pop;
    logic                w_halted;
    fetch_entry_t        w_head;

    // Handshakes: flush suppresses both sides; full queue never pops through
    assign in_ready  = (r_count_q != c_FULL) && !flush && !w_halted;
    assign out_valid = (r_count_q != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;

    ifq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_push),
        .i_clr (flush),
        .o_ptr (w_wr_ptr)
    );

    ifq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_pop),
        .i_clr (flush),
        .o_ptr (w_rd_ptr)
    );

    // Storage next-state: only the slot under the write pointer changes
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_d[i] = r_mem_q[i];
        end
        if (w_push) begin
            w_mem_d[w_wr_ptr] = '{pc: in_pc, instr: in_instr};
        end
    end

    // Storage registers, cleared on reset so no unknowns ever reach the head
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= w_mem_d[i];
            end
        end
    end

    // Occupancy: flush empties, push+pop together leaves it unchanged
    always_comb begin
        w_count_d = r_count_q;
        if (flush) begin
            w_count_d = '0;
        end else if (w_push && !w_pop) begin
            w_count_d = r_count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_d = r_count_q - 1'b1;
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

`ifdef IFQ_HALT_DETECT_EN
    logic r_halted_q;
    logic w_halted_d;

    // Halt latch: set by an accepted HLT opcode, cleared only by flush
    always_comb begin
        w_halted_d = r_halted_q;
        if (flush) begin
            w_halted_d = 1'b0;
        end else if (w_push && (in_instr[15:12] == OPC_HLT)) begin
            w_halted_d = 1'b1;
        end
    end

    // Halt register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_halted_q <= 1'b0;
        end else begin
            r_halted_q <= w_halted_d;
        end
    end

    assign w_halted = r_halted_q;
`else
    assign w_halted = 1'b0;
`endif

    // Head entry is forced to zero when the queue is empty
    assign w_head       = r_mem_q[w_rd_ptr];
    assign out_pc       = out_valid ? w_head.pc    : 16'h0000;
    assign out_instr    = out_valid ? w_head.instr : 16'h0000;
    assign out_pc_plus2 = out_pc + 16'd2;
    assign count        = r_count_q;
    assign halted       = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_queue
//  Description : Self-checking bench for if_id_queue. A queue-based model of
//                the FIFO holds expected entries; a negedge monitor compares
//                status and head outputs and retires entries on each pop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_queue;

    localparam int DEPTH = 4;
`ifdef IFQ_HALT_DETECT_EN
    localparam bit c_HALT_EN = 1'b1;
`else
    localparam bit c_HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_pc_plus2;
    logic [15:0] out_instr;
    logic        flush;
    logic [2:0]  count;
    logic        halted;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus2 (out_pc_plus2),
        .out_instr    (out_instr),
        .flush        (flush),
        .count        (count),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t exp_q[$];
    bit   m_halted = 1'b0;
    bit   mon_en   = 1'b0;
    bit   acc_ok   = 1'b0;
    int   n_cmp    = 0;
    int   n_err    = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare against the model before the upcoming rising edge
    always @(negedge clk) begin : mon
        bit   exp_rdy;
        ent_t h;
        if (mon_en) begin
            exp_rdy = (exp_q.size() != DEPTH) && !flush && !m_halted;
            acc_ok  = exp_rdy;
            check("count",     {29'd0, count},     exp_q.size());
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            check("in_ready",  {31'd0, in_ready},  {31'd0, exp_rdy});
            check("halted",    {31'd0, halted},    {31'd0, m_halted});
            if (exp_q.size() == 0) begin
                check("empty_pc",    {16'd0, out_pc},       32'h0);
                check("empty_instr", {16'd0, out_instr},    32'h0);
                check("empty_plus2", {16'd0, out_pc_plus2}, 32'h2);
            end else begin
                h = exp_q[0];
                check("head_pc",    {16'd0, out_pc},       {16'd0, h.pc});
                check("head_instr", {16'd0, out_instr},    {16'd0, h.instr});
                check("head_plus2", {16'd0, out_pc_plus2}, {16'd0, h.pc + 16'd2});
                if (out_ready && !flush && rst) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Apply one cycle of stimulus and advance the model at the clock edge
    task automatic drive(input bit rstn, input bit v, input logic [15:0] pc,
                         input logic [15:0] ins, input bit ordy, input bit fl);
        rst       = rstn;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (!rstn || fl) begin
            exp_q.delete();
            m_halted = 1'b0;
        end else if (v && acc_ok) begin
            exp_q.push_back('{pc, ins});
            if (c_HALT_EN && ins[15:12] == 4'hF) begin
                m_halted = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0;
        #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        mon_en = 1'b1;
        drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0);   // push during reset dropped

        // Single push, visible the following cycle
        drive(1'b1, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("first_pc_plus2", {16'd0, out_pc_plus2}, 32'h0002);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Fill, overflow attempt, drain in order
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b1, 16'h0100 + 16'(i * 2), 16'h1000 + 16'(i), 1'b0, 1'b0);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

        // Full with push+pop offered: pop only
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b1, 16'h0200 + 16'(i * 2), 16'h2000 + 16'(i), 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h0300, 16'h3000, 1'b1, 1'b0);
        check("pop_only_count", {29'd0, count}, 32'd3);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        // Half full, streaming push+pop wraps pointers
        for (int i = 0; i < 12; i++)
            drive(1'b1, 1'b1, 16'h0400 + 16'(i * 2), 16'h4000 + 16'(i), 1'b1, 1'b0);
        check("stream_count", {29'd0, count}, 32'd2);

        // Count 3 then flush with a push offered
        drive(1'b1, 1'b1, 16'h0500, 16'h5000, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h0502, 16'h5001, 1'b0, 1'b1);
        check("flush_count", {29'd0, count}, 32'd0);

        // Halt opcode followed by more pushes, then flush
        drive(1'b1, 1'b1, 16'h0600, 16'hF000, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h0602, 16'h6001, 1'b0, 1'b0);
        check("halt_state", {31'd0, halted}, {31'd0, c_HALT_EN});
        drive(1'b1, 1'b1, 16'h0604, 16'h6002, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // PC wrap on +2, then reset mid-stream
        drive(1'b1, 1'b1, 16'hFFFE, 16'h7000, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h0700, 16'hF001, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h0702, 16'h7002, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 16'h0704, 16'h7003, 1'b1, 1'b0);
        check("reset_count", {29'd0, count}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'($urandom);
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), pc,
                  16'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end

        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
